// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the RAM arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } arb_state_t;

  typedef enum logic {
    REQ_CORE,
    REQ_HOST
  } req_id_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester, lock and RAM-side signal bundle for ram_arbiter
interface ram_arbiter_if #(
  parameter int word_width = 8,
  parameter int addr_width = 3
);

  logic                  core_req;
  logic                  core_we;
  logic [addr_width-1:0] core_addr;
  logic [word_width-1:0] core_wdata;
  logic                  core_ack;
  logic [word_width-1:0] core_rdata;

  logic                  host_req;
  logic                  host_we;
  logic [addr_width-1:0] host_addr;
  logic [word_width-1:0] host_wdata;
  logic                  host_lock;
  logic                  host_ack;
  logic [word_width-1:0] host_rdata;
  logic                  host_owns;

  logic                  ram_en;
  logic                  ram_we;
  logic [addr_width-1:0] ram_addr;
  logic [word_width-1:0] ram_wdata;
  logic [word_width-1:0] ram_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_ack, core_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_ack, host_rdata, host_owns,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Requesters plus the RAM macro.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_ack, core_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_ack, host_rdata, host_owns,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-way winner selection; ARB_ROUND_ROBIN_EN selects round-robin over host-first priority
module arb_pick2
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_eligible,
  input  req_id_t            i_last_grant,
  output logic               o_grant,
  output req_id_t            o_winner
);

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority never looks at history.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

  // Bit 1 is the host, bit 0 the core; contention is the only case that needs a policy.
  always_comb begin
    o_grant  = |i_eligible;
    o_winner = REQ_CORE;
    if (i_eligible == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_winner = (i_last_grant == REQ_HOST) ? REQ_CORE : REQ_HOST;
`else
      o_winner = REQ_HOST;
`endif
    end else if (i_eligible[1]) begin
      o_winner = REQ_HOST;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - core/host single-port RAM arbiter with host lock; ARB_ROUND_ROBIN_EN enables round-robin
module ram_arbiter
  import arb_pkg::*;
#(
  parameter int word_width = 8,
  parameter int addr_width = 3
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  req_id_t               r_id;
  logic                  r_we;
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [addr_width-1:0] r_ram_addr;
  logic [word_width-1:0] r_ram_wdata;
  logic                  r_core_ack;
  logic                  r_host_ack;
  logic [word_width-1:0] r_core_rdata;
  logic [word_width-1:0] r_host_rdata;
  logic                  r_host_owns;

  req_id_t               w_last_grant;
  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_grant;
  req_id_t               w_winner;
  logic                  w_sel_we;
  logic [addr_width-1:0] w_sel_addr;
  logic [word_width-1:0] w_sel_wdata;
  logic [word_width-1:0] w_result;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t r_last_grant;

  // Remember who completed last so contention alternates; reset leaves the host favoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= REQ_CORE;
    end else if (r_state == CAPTURE) begin
      r_last_grant <= r_id;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = REQ_CORE;
`endif

  // Eligibility only matters in IDLE; a requester is masked in its own ack cycle and the
  // core is shut out as soon as the lock is seen, which is also when host_owns is loaded.
  always_comb begin
    w_eligible = '0;
    if (r_state == IDLE) begin
      w_eligible[1] = bus.host_req & ~r_host_ack;
      w_eligible[0] = bus.core_req & ~r_core_ack & ~bus.host_lock;
    end
  end

  arb_pick2 u_pick (
    .i_eligible   (w_eligible),
    .i_last_grant (w_last_grant),
    .o_grant      (w_grant),
    .o_winner     (w_winner)
  );

  // Winner's request fields, and the word returned to it at completion.
  always_comb begin
    w_sel_we    = bus.core_we;
    w_sel_addr  = bus.core_addr;
    w_sel_wdata = bus.core_wdata;
    if (w_winner == REQ_HOST) begin
      w_sel_we    = bus.host_we;
      w_sel_addr  = bus.host_addr;
      w_sel_wdata = bus.host_wdata;
    end
    w_result = r_we ? r_ram_wdata : bus.ram_rdata;
  end

  // Transaction sequencing: every access takes IDLE -> ISSUE -> CAPTURE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next_state = ISSUE;
      ISSUE:   w_next_state = CAPTURE;
      CAPTURE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the granted access, drive the RAM strobe for one cycle, then return data and ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id         <= REQ_CORE;
      r_we         <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_core_ack   <= 1'b0;
      r_host_ack   <= 1'b0;
      r_core_rdata <= '0;
      r_host_rdata <= '0;
      r_host_owns  <= 1'b0;
    end else begin
      r_core_ack <= 1'b0;
      r_host_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_host_owns <= bus.host_lock;
          if (w_grant) begin
            r_id        <= w_winner;
            r_we        <= w_sel_we;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_sel_we;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
          end
        end
        ISSUE: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
        end
        CAPTURE: begin
          if (r_id == REQ_HOST) begin
            r_host_ack   <= 1'b1;
            r_host_rdata <= w_result;
          end else begin
            r_core_ack   <= 1'b1;
            r_core_rdata <= w_result;
          end
        end
        default: begin
          r_ram_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_en     = r_ram_en;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.core_ack   = r_core_ack;
  assign bus.core_rdata = r_core_rdata;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_rdata = r_host_rdata;
  assign bus.host_owns  = r_host_owns;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with directed scenarios and a randomized reference model
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] ram_mem [8];

  always #5 clk = ~clk;

  ram_arbiter_if #(.word_width(8), .addr_width(3)) bus ();

  ram_arbiter #(.word_width(8), .addr_width(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-port synchronous RAM, read-first, data valid the cycle after ram_en.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  task automatic clear_inputs();
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_lock = 0;
  endtask

  // Runs one access from an idle requester; called and returning at a negedge, with one idle cycle after.
  task automatic do_access(input bit host, input bit we, input logic [2:0] addr, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd);
    lat = -1;
    rd = '0;
    if (host) begin
      bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd; bus.host_req = 1;
    end else begin
      bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wd; bus.core_req = 1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (host && bus.host_ack) begin lat = i; rd = bus.host_rdata; break; end
      if (!host && bus.core_ack) begin lat = i; rd = bus.core_rdata; break; end
    end
    bus.host_req = 0;
    bus.core_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", bus.ram_en); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 3'd0 || bus.ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_bus: got %h/%h want 0/00", bus.ram_addr, bus.ram_wdata); end
    checks++; if (bus.core_ack !== 1'b0 || bus.host_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b want 00", bus.core_ack, bus.host_ack); end
    checks++; if (bus.core_rdata !== 8'h00 || bus.host_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h/%h want 00/00", bus.core_rdata, bus.host_rdata); end
    checks++; if (bus.host_owns !== 1'b0) begin errors++; $display("FAIL reset_owns: got %b want 0", bus.host_owns); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int lat;
    logic [7:0] rd;
    do_access(1, 1, 3'd5, 8'h3C, lat, rd);
    bus.core_we = 0; bus.core_addr = 3'd5; bus.core_req = 1;
    @(negedge clk);
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 3'd5 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL single_issue: got en=%b addr=%0d we=%b want 1/5/0", bus.ram_en, bus.ram_addr, bus.ram_we); end
    checks++; if (bus.core_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack1: got %b want 0", bus.core_ack); end
    @(negedge clk);
    checks++; if (bus.ram_en !== 1'b0 || bus.core_ack !== 1'b0) begin errors++; $display("FAIL single_capture: got en=%b ack=%b want 0/0", bus.ram_en, bus.core_ack); end
    @(negedge clk);
    checks++; if (bus.core_ack !== 1'b1 || bus.core_rdata !== 8'h3C) begin errors++; $display("FAIL single_ack: got ack=%b data=%h want 1/3c", bus.core_ack, bus.core_rdata); end
    bus.core_req = 0;
    @(negedge clk);
    checks++; if (bus.core_ack !== 1'b0 || bus.ram_en !== 1'b0) begin errors++; $display("FAIL single_after: got ack=%b en=%b want 0/0", bus.core_ack, bus.ram_en); end
  endtask

  task automatic test_write_then_read();
    int lat;
    logic [7:0] rd;
    do_access(1, 1, 3'd2, 8'hA5, lat, rd);
    checks++; if (lat != 3 || rd !== 8'hA5) begin errors++; $display("FAIL wr_host_write: got lat=%0d data=%h want 3/a5", lat, rd); end
    checks++; if (ram_mem[2] !== 8'hA5) begin errors++; $display("FAIL wr_ram_content: got %h want a5", ram_mem[2]); end
    do_access(0, 0, 3'd2, 8'h00, lat, rd);
    checks++; if (lat != 3 || rd !== 8'hA5) begin errors++; $display("FAIL wr_core_read: got lat=%0d data=%h want 3/a5", lat, rd); end
  endtask

  task automatic test_contention();
    int lat;
    logic [7:0] rd;
    bit got[$];
    do_access(1, 1, 3'd3, 8'h33, lat, rd);
    do_access(1, 1, 3'd4, 8'h44, lat, rd);
    do_access(0, 0, 3'd3, 8'h00, lat, rd);
    checks++; if (rd !== 8'h33) begin errors++; $display("FAIL cont_setup_read: got %h want 33", rd); end
    bus.core_we = 0; bus.core_addr = 3'd3; bus.core_req = 1;
    bus.host_we = 0; bus.host_addr = 3'd4; bus.host_req = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        got.push_back(1'b1);
        checks++; if (bus.host_rdata !== 8'h44) begin errors++; $display("FAIL cont_host_data: got %h want 44", bus.host_rdata); end
      end
      if (bus.core_ack) begin
        got.push_back(1'b0);
        checks++; if (bus.core_rdata !== 8'h33) begin errors++; $display("FAIL cont_core_data: got %h want 33", bus.core_rdata); end
      end
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL cont_ack_count: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== ((k % 2) == 0)) begin errors++; $display("FAIL cont_order[%0d]: got host=%b want host=%b", k, got[k], (k % 2) == 0); end
    end
  endtask

  task automatic test_policy();
    int lat;
    logic [7:0] rd;
    int first_lat = -1;
    bit first_host = 0;
    bit want_host;
`ifdef ARB_ROUND_ROBIN_EN
    want_host = 0;
`else
    want_host = 1;
`endif
    do_access(1, 0, 3'd4, 8'h00, lat, rd);
    bus.core_we = 0; bus.core_addr = 3'd3; bus.core_req = 1;
    bus.host_we = 0; bus.host_addr = 3'd4; bus.host_req = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.host_ack || bus.core_ack) begin first_lat = i; first_host = bus.host_ack; break; end
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (first_lat != 3 || first_host !== want_host) begin errors++; $display("FAIL policy_first: got lat=%0d host=%b want 3/%b", first_lat, first_host, want_host); end
  endtask

  task automatic test_lock();
    int lat;
    logic [7:0] rd;
    int core_acks = 0;
    int host_acks = 0;
    do_access(1, 1, 3'd1, 8'h11, lat, rd);
    do_access(1, 1, 3'd7, 8'hE7, lat, rd);
    bus.core_we = 0; bus.core_addr = 3'd1; bus.core_req = 1;
    @(negedge clk);
    bus.host_lock = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.core_ack !== 1'b1 || bus.core_rdata !== 8'h11) begin errors++; $display("FAIL lock_inflight: got ack=%b data=%h want 1/11", bus.core_ack, bus.core_rdata); end
    bus.core_addr = 3'd7;
    @(negedge clk);
    checks++; if (bus.host_owns !== 1'b1) begin errors++; $display("FAIL lock_owns_rise: got %b want 1", bus.host_owns); end
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin bus.host_we = 1; bus.host_addr = 3'd0; bus.host_wdata = 8'h5A; bus.host_req = 1; end
      @(negedge clk);
      if (bus.core_ack) core_acks++;
      if (bus.host_ack) begin host_acks++; bus.host_req = 0; end
    end
    checks++; if (core_acks != 0) begin errors++; $display("FAIL lock_core_blocked: got %0d acks want 0", core_acks); end
    checks++; if (host_acks != 1 || ram_mem[0] !== 8'h5A) begin errors++; $display("FAIL lock_host_write: got acks=%0d ram=%h want 1/5a", host_acks, ram_mem[0]); end
    bus.host_lock = 0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++; if (bus.host_owns !== 1'b0) begin errors++; $display("FAIL lock_owns_fall: got %b want 0", bus.host_owns); end
      end
      if (bus.core_ack) begin lat = i; rd = bus.core_rdata; break; end
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (lat != 3 || rd !== 8'hE7) begin errors++; $display("FAIL lock_release_grant: got lat=%0d data=%h want 3/e7", lat, rd); end
  endtask

  task automatic test_held_req();
    bus.core_we = 0; bus.core_addr = 3'd3; bus.core_req = 1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 3) begin
        checks++; if (bus.core_ack !== 1'b1 || bus.core_rdata !== 8'h33) begin errors++; $display("FAIL held_first_ack: got ack=%b data=%h want 1/33", bus.core_ack, bus.core_rdata); end
      end
      if (n == 4) begin
        checks++; if (bus.ram_en !== 1'b0 || bus.core_ack !== 1'b0) begin errors++; $display("FAIL held_no_dup: got en=%b ack=%b want 0/0", bus.ram_en, bus.core_ack); end
      end
      if (n == 5) begin
        checks++; if (bus.ram_en !== 1'b1) begin errors++; $display("FAIL held_next_grant: got en=%b want 1", bus.ram_en); end
      end
      if (n == 7) begin
        checks++; if (bus.core_ack !== 1'b1) begin errors++; $display("FAIL held_second_ack: got %b want 1", bus.core_ack); end
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_in_issue();
    int lat;
    logic [7:0] rd;
    bus.host_we = 1; bus.host_addr = 3'd6; bus.host_wdata = 8'h77; bus.host_req = 1;
    @(negedge clk);
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 3'd6) begin errors++; $display("FAIL rst_issue_setup: got en=%b addr=%0d want 1/6", bus.ram_en, bus.ram_addr); end
    reset = 1;
    bus.host_req = 0;
    @(negedge clk);
    checks++; if (ram_mem[6] !== 8'h77) begin errors++; $display("FAIL rst_ram_written: got %h want 77", ram_mem[6]); end
    checks++; if (bus.host_ack !== 1'b0 || bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got ack=%b en=%b we=%b want 0/0/0", bus.host_ack, bus.ram_en, bus.ram_we); end
    checks++; if (bus.ram_addr !== 3'd0 || bus.ram_wdata !== 8'h00 || bus.host_rdata !== 8'h00 || bus.core_rdata !== 8'h00) begin errors++; $display("FAIL rst_outputs: got %h/%h/%h/%h want zeros", bus.ram_addr, bus.ram_wdata, bus.host_rdata, bus.core_rdata); end
    reset = 0;
    @(negedge clk);
    checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got %b want 0", bus.host_ack); end
    do_access(0, 0, 3'd6, 8'h00, lat, rd);
    checks++; if (lat != 3 || rd !== 8'h77) begin errors++; $display("FAIL rst_idle_after: got lat=%0d data=%h want 3/77", lat, rd); end
  endtask

  // Reference model: an access occupies the RAM for three cycles counted down from the grant;
  // memory contents follow grant order.
  task automatic test_random();
    logic [7:0] ref_mem [8];
    int cnt = 0;
    bit cur_host = 0, cur_we = 0, last_host = 0;
    logic [2:0] cur_addr = '0;
    logic [7:0] cur_res = '0, e_crd = '0, e_hrd = '0;
    bit e_en = 0, e_cack = 0, e_hack = 0, e_owns = 0;
    bit eh, ec, pick_host, n_cack, n_hack;
    clear_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = ram_mem[i];
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (bus.ram_en !== e_en) begin errors++; $display("FAIL rnd_ram_en @%0d: got %b want %b", cyc, bus.ram_en, e_en); end
      checks++; if (bus.core_ack !== e_cack) begin errors++; $display("FAIL rnd_core_ack @%0d: got %b want %b", cyc, bus.core_ack, e_cack); end
      checks++; if (bus.host_ack !== e_hack) begin errors++; $display("FAIL rnd_host_ack @%0d: got %b want %b", cyc, bus.host_ack, e_hack); end
      checks++; if (bus.core_rdata !== e_crd) begin errors++; $display("FAIL rnd_core_rdata @%0d: got %h want %h", cyc, bus.core_rdata, e_crd); end
      checks++; if (bus.host_rdata !== e_hrd) begin errors++; $display("FAIL rnd_host_rdata @%0d: got %h want %h", cyc, bus.host_rdata, e_hrd); end
      checks++; if (bus.host_owns !== e_owns) begin errors++; $display("FAIL rnd_owns @%0d: got %b want %b", cyc, bus.host_owns, e_owns); end
      if (e_en) begin
        checks++; if (bus.ram_addr !== cur_addr || bus.ram_we !== cur_we) begin errors++; $display("FAIL rnd_ram_access @%0d: got %0d/%b want %0d/%b", cyc, bus.ram_addr, bus.ram_we, cur_addr, cur_we); end
      end
      if (e_cack || (!bus.core_req && $urandom_range(0, 3) == 0)) begin
        bus.core_req = e_cack ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.core_we = 1'($urandom_range(0, 1)); bus.core_addr = 3'($urandom_range(0, 7)); bus.core_wdata = 8'($urandom);
      end
      if (e_hack || (!bus.host_req && $urandom_range(0, 3) == 0)) begin
        bus.host_req = e_hack ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.host_we = 1'($urandom_range(0, 1)); bus.host_addr = 3'($urandom_range(0, 7)); bus.host_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 24) == 0) bus.host_lock = ~bus.host_lock;
      n_cack = 0;
      n_hack = 0;
      if (cnt == 0) begin
        e_owns = bus.host_lock;
        eh = bus.host_req && !e_hack;
        ec = bus.core_req && !e_cack && !bus.host_lock;
        e_en = eh || ec;
        if (eh || ec) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick_host = (eh && ec) ? !last_host : eh;
`else
          pick_host = eh;
`endif
          cur_host = pick_host;
          cur_we   = pick_host ? bus.host_we : bus.core_we;
          cur_addr = pick_host ? bus.host_addr : bus.core_addr;
          cur_res  = cur_we ? (pick_host ? bus.host_wdata : bus.core_wdata) : ref_mem[cur_addr];
          if (cur_we) ref_mem[cur_addr] = cur_res;
          cnt = 2;
        end
      end else begin
        e_en = 0;
        cnt--;
        if (cnt == 0) begin
          if (cur_host) begin n_hack = 1; e_hrd = cur_res; end
          else begin n_cack = 1; e_crd = cur_res; end
          last_host = cur_host;
        end
      end
      e_cack = n_cack;
      e_hack = n_hack;
      @(negedge clk);
    end
    clear_inputs();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_then_read();
    test_contention();
    test_policy();
    test_lock();
    test_held_req();
    test_reset_in_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
